sequence_line_embedder: RTL and testbench
=========================================

Name: sequence_line_embedder

Overview:
- Parametrised successor of the single-word sequence generator.
- Serialises a latched payload word across one active video line of interleaved 4:2:2 samples (Cb Y Cr Y …).
- Each payload bit is held for a fixed run of samples: luma positions carry WHITE_LEVEL/BLACK_LEVEL, chroma positions carry CHROMA_NEUTRAL.
- Adds a start/ready handshake, a sample-enable strobe instead of a derived divided clock, abort, and a done pulse. Sits between the reseed/ID source and the video output mux.

Parameters:
- PAYLOAD_BITS, 40, payload width (ID byte plus 32-bit reseed count); ≥ 1.
- SAMPLES_PER_LINE, 1440, interleaved samples per active line. Must be divisible by 2*TOTAL_BITS; violation is an elaboration error.
- SAMPLE_WIDTH, 10, sample bit width.
- BLACK_LEVEL, 10'h040, luma level for bit 0 (BT.601 nominal black, never blanking level).
- WHITE_LEVEL, 10'h3AC, luma level for bit 1.
- CHROMA_NEUTRAL, 10'h200, value at every chroma position.
- Derived: TOTAL_BITS = PAYLOAD_BITS (+8 with CRC); SAMPLES_PER_BIT = SAMPLES_PER_LINE/TOTAL_BITS.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- payload_in  in  PAYLOAD_BITS  word to send, MSB first.
- start  in  1  request; accepted on an edge where start && ready.
- ready  out  1  high in IDLE only.
- abort  in  1  cancel an active line.
- sample_en  in  1  one-cycle strobe per sample slot (pixel-rate enable).
- sample_out  out  SAMPLE_WIDTH  registered sample value.
- sample_valid  out  1  sample_out belongs to an active transmission.
- busy  out  1  high in ACTIVE.
- done  out  1  one-cycle pulse when the final sample has been issued.

Behaviour:
- Reset: state IDLE, ready=1, busy=0, done=0, sample_valid=0, sample_out=BLACK_LEVEL, all counters 0, shift register 0. Reset overrides start, abort and sample_en.
- States: IDLE, ACTIVE.
- IDLE → ACTIVE on start && ready. payload_in is latched that edge; sample_idx=0, bit_cnt=0, hold_cnt=0. ready drops and busy rises the next cycle. start while busy is ignored.
- ACTIVE, each edge with sample_en=1:
  - Even sample_idx (chroma): sample_out <= CHROMA_NEUTRAL.
  - Odd sample_idx (luma): sample_out <= current MSB ? WHITE_LEVEL : BLACK_LEVEL.
  - sample_valid <= 1; sample_idx increments.
  - hold_cnt counts 0..SAMPLES_PER_BIT-1. On wrap, the shift register shifts left 1 and bit_cnt increments. No dividers.
- Latency: sample_out and sample_valid update on the same edge that samples sample_en=1, and hold until the next strobe. A strobe on the acceptance edge itself is not consumed; the first consumed strobe is the next one.
- Last sample (sample_idx = SAMPLES_PER_LINE-1 with sample_en): that sample is issued, done=1 for one cycle, state → IDLE. ready=1 and busy=0 the following cycle.
- In IDLE, sample_en drives sample_valid <= 0 and sample_out <= BLACK_LEVEL.
- Abort in ACTIVE: state → IDLE, sample_valid <= 0, sample_out <= BLACK_LEVEL, no done. Abort has priority over a coincident sample_en. Abort in IDLE has no effect.
- Abort and start on the same edge in IDLE: start is accepted.
- Done and a new start in the same cycle: start is not accepted, because ready is still 0.
- Counter widths are $clog2-sized. sample_idx never exceeds SAMPLES_PER_LINE-1.

Optional Feature:
- Macro: SEQUENCE_CRC8_EN.
- Defined: CRC-8, poly 0x07, init 0x00, no reflection, computed MSB first over the latched payload. Appended after the payload LSB, so TOTAL_BITS = PAYLOAD_BITS+8 and SAMPLES_PER_BIT shrinks to match (1440/48 = 30). The CRC is ready before the first consumed strobe.
- Undefined: no CRC logic; TOTAL_BITS = PAYLOAD_BITS (1440/40 = 36).

Decomposition:
- Package sequence_pkg holds:
  - BT.601 level constants (BLACK, WHITE, CHROMA_NEUTRAL);
  - CRC8_POLY = 8'h07;
  - state enum {IDLE, ACTIVE};
  - function crc8_step.
- Sub-module sequence_crc8: combinational/parametric CRC over PAYLOAD_BITS, instantiated only under SEQUENCE_CRC8_EN.

Test Plan:
- Reset, then 10 strobes without start → ready=1, busy=0, sample_valid=0, sample_out=0x040 throughout.
- payload 40'h80_0000_0000, start, 1440 strobes:
  - odd samples 1..35 = 0x3AC;
  - odd samples 37..1439 = 0x040;
  - all even samples = 0x200;
  - done pulses exactly once on strobe 1440, then ready=1.
- payload 40'hA5_0000_0001: bit 0 (samples 1404..1439) odd = 0x3AC; bits 39,37 white; bits 38,36 black; bit boundaries every 36 samples.
- Abort after strobe 500 → sample_valid=0 next edge, no done, ready=1. A following start sends a full line from bit 39.
- start held high during ACTIVE plus reset asserted mid-line → start ignored while busy; reset returns all outputs to reset values in one edge.
- SEQUENCE_CRC8_EN, payload 40'h00_0000_0001 → CRC 0x07 in final 8 bits: samples 1200..1439 show bits 00000111. SAMPLES_PER_BIT = 30.

Source files
------------

// File: rtl/sequence_pkg.sv
// Shared levels, CRC polynomial and FSM state type for the line embedder.
// Purely declarative: no latency, no flow control.
package sequence_pkg;

    localparam logic [9:0] BT601_BLACK          = 10'h040;
    localparam logic [9:0] BT601_WHITE          = 10'h3AC;
    localparam logic [9:0] BT601_CHROMA_NEUTRAL = 10'h200;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/sequence_line_embedder_if.sv
// Control/sample bundle between the payload source and the embedder.
// master = payload/strobe driver, slave = embedder; no internal storage.
interface sequence_line_embedder_if #(
    parameter int PAYLOAD_BITS = 40,
    parameter int SAMPLE_WIDTH = 10
);
    logic [PAYLOAD_BITS-1:0] payload_in;
    logic                    start;
    logic                    ready;
    logic                    abort;
    logic                    sample_en;
    logic [SAMPLE_WIDTH-1:0] sample_out;
    logic                    sample_valid;
    logic                    busy;
    logic                    done;

    modport master (
        output payload_in, start, abort, sample_en,
        input  ready, sample_out, sample_valid, busy, done
    );

    modport slave (
        input  payload_in, start, abort, sample_en,
        output ready, sample_out, sample_valid, busy, done
    );
endinterface

// File: rtl/sequence_line_embedder_crc8.sv
// CRC-8 (poly 0x07, init 0, unreflected) over the payload, MSB first.
// Combinational, zero latency; no flow control.
module sequence_crc8
    import sequence_pkg::*;
#(
    parameter int PAYLOAD_BITS = 40
) (
    input  logic [PAYLOAD_BITS-1:0] data_i,
    output logic [7:0]              crc_o
);

    always_comb begin
        crc_o = 8'h00;
        for (int i = PAYLOAD_BITS - 1; i >= 0; i--) begin
            crc_o = crc8_step(crc_o, data_i[i]);
        end
    end

endmodule

// File: rtl/sequence_line_embedder.sv
// Serialises a latched payload (plus CRC-8 when SEQUENCE_CRC8_EN) over one 4:2:2 line.
// Outputs update on the sample_en edge; ready only in IDLE, new starts wait one cycle after done.
module sequence_line_embedder
    import sequence_pkg::*;
#(
    parameter int                    PAYLOAD_BITS     = 40,
    parameter int                    SAMPLES_PER_LINE = 1440,
    parameter int                    SAMPLE_WIDTH     = 10,
    parameter logic [SAMPLE_WIDTH-1:0] BLACK_LEVEL    = SAMPLE_WIDTH'(BT601_BLACK),
    parameter logic [SAMPLE_WIDTH-1:0] WHITE_LEVEL    = SAMPLE_WIDTH'(BT601_WHITE),
    parameter logic [SAMPLE_WIDTH-1:0] CHROMA_NEUTRAL = SAMPLE_WIDTH'(BT601_CHROMA_NEUTRAL)
) (
    input logic                   clock,
    input logic                   reset,
    sequence_line_embedder_if.slave bus
);

`ifdef SEQUENCE_CRC8_EN
    localparam int TOTAL_BITS = PAYLOAD_BITS + 8;
`else
    localparam int TOTAL_BITS = PAYLOAD_BITS;
`endif
    localparam int SAMPLES_PER_BIT = SAMPLES_PER_LINE / TOTAL_BITS;
    localparam int IDX_W  = (SAMPLES_PER_LINE > 1) ? $clog2(SAMPLES_PER_LINE) : 1;
    localparam int HOLD_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam int BIT_W  = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SAMPLES_PER_LINE - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(SAMPLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(TOTAL_BITS - 1);

    if (PAYLOAD_BITS < 1) begin : g_bad_payload
        $error("sequence_line_embedder: PAYLOAD_BITS must be >= 1");
    end
    if (SAMPLES_PER_LINE % (2 * TOTAL_BITS) != 0) begin : g_bad_line
        $error("sequence_line_embedder: SAMPLES_PER_LINE must be divisible by 2*TOTAL_BITS");
    end

    logic [TOTAL_BITS-1:0] load_word;

`ifdef SEQUENCE_CRC8_EN
    logic [7:0] crc;

    sequence_crc8 #(
        .PAYLOAD_BITS(PAYLOAD_BITS)
    ) u_crc8 (
        .data_i(bus.payload_in),
        .crc_o (crc)
    );

    assign load_word = {bus.payload_in, crc};
`else
    assign load_word = bus.payload_in;
`endif

    state_t                  state_q;
    logic [TOTAL_BITS-1:0]   shreg_q;
    logic [IDX_W-1:0]        sample_idx_q;
    logic [HOLD_W-1:0]       hold_cnt_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    sample_valid_q;
    logic [SAMPLE_WIDTH-1:0] sample_out_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            sample_idx_q   <= '0;
            hold_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            ready_q        <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_out_q   <= BLACK_LEVEL;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.sample_en) begin
                        sample_valid_q <= 1'b0;
                        sample_out_q   <= BLACK_LEVEL;
                    end
                    // ready_q lags the return to IDLE by one cycle, so a start
                    // coinciding with done is never accepted.
                    if (bus.start && ready_q) begin
                        state_q      <= ACTIVE;
                        shreg_q      <= load_word;
                        sample_idx_q <= '0;
                        hold_cnt_q   <= '0;
                        bit_cnt_q    <= '0;
                        ready_q      <= 1'b0;
                        busy_q       <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (bus.abort) begin
                        state_q        <= IDLE;
                        sample_valid_q <= 1'b0;
                        sample_out_q   <= BLACK_LEVEL;
                    end else if (bus.sample_en) begin
                        sample_valid_q <= 1'b1;
                        if (sample_idx_q[0]) begin
                            sample_out_q <= shreg_q[TOTAL_BITS-1] ? WHITE_LEVEL : BLACK_LEVEL;
                        end else begin
                            sample_out_q <= CHROMA_NEUTRAL;
                        end
                        if (hold_cnt_q == LAST_HOLD) begin
                            hold_cnt_q <= '0;
                            if (bit_cnt_q != LAST_BIT) begin
                                shreg_q   <= shreg_q << 1;
                                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                        if (sample_idx_q == LAST_IDX) begin
                            sample_idx_q <= '0;
                            done_q       <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            sample_idx_q <= sample_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready        = ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_out   = sample_out_q;

endmodule

// File: tb/tb_sequence_line_embedder.sv
// Randomised bench for sequence_line_embedder: a reference model queues expected samples per line,
// a monitor pops and compares on every consumed strobe.
module tb_sequence_line_embedder;

    localparam int PB  = 40;
    localparam int SPL = 1440;
    localparam int SW  = 10;
`ifdef SEQUENCE_CRC8_EN
    localparam int TB_BITS = PB + 8;
`else
    localparam int TB_BITS = PB;
`endif
    localparam int SPB = SPL / TB_BITS;

    typedef struct packed {
        logic [SW-1:0] s;
        logic          last;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sequence_line_embedder_if #(.PAYLOAD_BITS(PB), .SAMPLE_WIDTH(SW)) bus ();

    sequence_line_embedder #(
        .PAYLOAD_BITS    (PB),
        .SAMPLES_PER_LINE(SPL),
        .SAMPLE_WIDTH    (SW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic en_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Transmitted word: payload followed by its CRC remainder from long division by x^8+x^2+x+1.
    function automatic logic [TB_BITS-1:0] line_word(input logic [PB-1:0] p);
`ifdef SEQUENCE_CRC8_EN
        logic [PB+7:0] rem;
        rem = {p, 8'h00};
        for (int i = PB + 7; i >= 8; i--) begin
            if (rem[i]) rem[i-:9] = rem[i-:9] ^ 9'h107;
        end
        return {p, rem[7:0]};
`else
        return p;
`endif
    endfunction

    task automatic push_line(input logic [PB-1:0] p);
        logic [TB_BITS-1:0] w;
        exp_t e;
        w = line_word(p);
        for (int k = 0; k < SPL; k++) begin
            if (k % 2 == 0) e.s = 10'h200;
            else            e.s = w[TB_BITS - 1 - k / SPB] ? 10'h3AC : 10'h040;
            e.last = (k == SPL - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clock) en_seen <= bus.sample_en;

    always @(negedge clock) begin
        if (bus.done) done_cnt++;
        if (en_seen && bus.sample_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", bus.sample_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sample_out", bus.sample_out, mon_e.s);
                chk("done_on_sample", bus.done, mon_e.last);
            end
        end else if (bus.done) begin
            chk("spurious_done", bus.done, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_strobes(input int n);
        int cnt = 0;
        for (int c = 0; c < n * 4 + 16 && cnt < n; c++) begin
            bus.sample_en = ($urandom_range(0, 2) != 0);
            tick();
            if (bus.sample_en) cnt++;
        end
        bus.sample_en = 1'b0;
        if (cnt != n) chk("strobe_budget", cnt, n);
    endtask

    task automatic start_line(input logic [PB-1:0] p, input bit en_on_accept,
                              input bit abort_on_accept, input bit hold_start);
        chk("ready_before_start", bus.ready, 1'b1);
        bus.payload_in = p;
        bus.start      = 1'b1;
        bus.sample_en  = en_on_accept;
        bus.abort      = abort_on_accept;
        push_line(p);
        tick();
        bus.start      = hold_start;
        bus.sample_en  = 1'b0;
        bus.abort      = 1'b0;
        bus.payload_in = PB'({$urandom, $urandom});
        chk("busy_after_accept", bus.busy, 1'b1);
        chk("ready_after_accept", bus.ready, 1'b0);
    endtask

    task automatic full_line(input logic [PB-1:0] p, input bit abort_on_accept);
        done_cnt = 0;
        start_line(p, 1'b1, abort_on_accept, 1'b0);
        run_strobes(SPL);
        chk("done_pulse", bus.done, 1'b1);
        chk("ready_in_done_cycle", bus.ready, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ready_after_done", bus.ready, 1'b1);
        chk("busy_after_done", bus.busy, 1'b0);
        chk("done_one_cycle", bus.done, 1'b0);
        tick();
        chk("done_count", done_cnt, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.ready, 1'b1);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_done"}, bus.done, 1'b0);
        chk({tag, "_valid"}, bus.sample_valid, 1'b0);
        chk({tag, "_out"}, bus.sample_out, 10'h040);
    endtask

    initial begin
        reset          = 1'b1;
        bus.payload_in = '0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.sample_en  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_outputs("reset");

        for (int i = 0; i < 10; i++) begin
            bus.sample_en = 1'b1;
            tick();
            chk_reset_outputs("idle_strobe");
        end
        bus.sample_en = 1'b0;

        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle_abort_ready", bus.ready, 1'b1);

        full_line(40'h80_0000_0000, 1'b0);
        full_line(40'hA5_0000_0001, 1'b1);
`ifdef SEQUENCE_CRC8_EN
        full_line(40'h00_0000_0001, 1'b0);
`endif
        full_line(PB'({$urandom, $urandom}), 1'b0);

        done_cnt = 0;
        start_line(PB'({$urandom, $urandom}), 1'b0, 1'b0, 1'b0);
        run_strobes(500);
        bus.abort     = 1'b1;
        bus.sample_en = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.sample_en = 1'b0;
        exp_q.delete();
        chk("abort_valid", bus.sample_valid, 1'b0);
        chk("abort_out", bus.sample_out, 10'h040);
        tick();
        tick();
        chk("abort_ready", bus.ready, 1'b1);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_no_done", done_cnt, 0);
        full_line(PB'({$urandom, $urandom}), 1'b0);

        start_line(PB'({$urandom, $urandom}), 1'b1, 1'b0, 1'b1);
        run_strobes(300);
        reset         = 1'b1;
        bus.sample_en = 1'b1;
        tick();
        exp_q.delete();
        chk_reset_outputs("mid_reset");
        bus.start     = 1'b0;
        bus.sample_en = 1'b0;
        reset         = 1'b0;
        tick();
        chk("post_reset_ready", bus.ready, 1'b1);
        full_line(PB'({$urandom, $urandom}), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
